// File: rtl/rr_msdf_pkg.sv
// Shared definitions for the MSDF (most-significant-digit-first) blocks:
// the digit-width helper, the legal-radix check and the converter FSM states.
package rr_msdf_pkg;

  // Converter FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } otf_state_e;

  // Signed-digit width for a radix: log2(radix) magnitude bits plus a sign bit.
  function automatic int digit_width(input int radix);
    return $clog2(radix) + 1;
  endfunction

  // Only radices 2, 4 and 8 are supported by the converter.
  function automatic bit radix_is_legal(input int radix);
    return (radix == 2) || (radix == 4) || (radix == 8);
  endfunction

endpackage

// File: rtl/rr_otf_step.sv
// One on-the-fly conversion step: next Q and QM (QM = Q-1) for one
// signed digit, built by shifting left one digit and appending a digit.
// For d >= 0 Q takes Q as its base, otherwise QM; the appended low digit
// is d mod RADIX in both cases. For d > 0 QM takes Q as its base,
// otherwise QM; the appended low digit is (d-1) mod RADIX in both cases.
// The illegal code -RADIX is the one case where QM needs a borrow: its
// exact value QM*RADIX-1 is formed as (QM-1)*RADIX + (RADIX-1).
module rr_otf_step
  import rr_msdf_pkg::*;
#(
  parameter int  RADIX = 4,
  parameter int  W     = 17,
  localparam int K     = $clog2(RADIX),
  localparam int D     = digit_width(RADIX)
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  logic [D-1:0] digit,
  output logic [W-1:0] q_next,
  output logic [W-1:0] qm_next
);

  logic         neg;
  logic         zero;
  logic         pos;
  logic         illegal;
  logic [K-1:0] d_lo;
  logic [K-1:0] dm1_lo;
  logic [W-1:0] q_base;
  logic [W-1:0] qm_base;

  // Classify the digit and select shift bases plus appended low digits.
  always_comb begin
    neg     = digit[D-1];
    zero    = (digit == '0);
    pos     = !neg && !zero;
    illegal = neg && (digit[K-1:0] == '0);
    d_lo    = digit[K-1:0];
    dm1_lo  = digit[K-1:0] - K'(1);
    q_base  = neg ? qm : q;
    if (pos) begin
      qm_base = q;
    end else if (illegal) begin
      qm_base = qm - W'(1);
    end else begin
      qm_base = qm;
    end
    q_next  = {q_base[W-K-1:0], d_lo};
    qm_next = {qm_base[W-K-1:0], dm1_lo};
  end

endmodule

// File: rtl/rr_otf_convert.sv
// On-the-fly converter: accumulates N signed MSDF digits of radix RADIX
// into a W-bit two's-complement integer without a carry-propagate adder.
//
// Handshake: a digit moves on any rising edge where in_valid && in_ready;
// a result moves on any rising edge where out_valid && out_ready. Producer
// and consumer hold their data stable while waiting for the partner.
//
// Optional build macro RR_OTF_DIGIT_CHECK_EN adds the sticky digit_err
// output, set when the illegal digit code -RADIX is accepted.
module rr_otf_convert
  import rr_msdf_pkg::*;
#(
  parameter int  RADIX = 4,
  parameter int  N     = 8,
  localparam int K     = $clog2(RADIX),
  localparam int D     = digit_width(RADIX),
  localparam int W     = N * K + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [D-1:0] in_digit,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_value,
  input  logic         out_ready,
  output logic [1:0]   dbg_state
`ifdef RR_OTF_DIGIT_CHECK_EN
  ,
  output logic         digit_err
`endif
);

  localparam int            CW   = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!radix_is_legal(RADIX)) begin : g_bad_radix
    $error("rr_otf_convert: RADIX must be 2, 4 or 8");
  end

  otf_state_e    state;
  otf_state_e    state_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [W-1:0]  q;
  logic [W-1:0]  qm;
  logic [W-1:0]  q_step;
  logic [W-1:0]  qm_step;
  logic          load;
  logic          clear;

  // Q/QM next values for the digit currently on in_digit. In IDLE the
  // registers already hold Q=0/QM=-1, so the first digit needs no mux.
  rr_otf_step #(
    .RADIX (RADIX),
    .W     (W)
  ) u_step (
    .q       (q),
    .qm      (qm),
    .digit   (in_digit),
    .q_next  (q_step),
    .qm_next (qm_step)
  );

  // Next-state, counter and register-control decode.
  always_comb begin
    state_next = state;
    count_next = count;
    load       = 1'b0;
    clear      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          count_next = CW'(1);
          state_next = (N == 1) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          load       = 1'b1;
          count_next = count + CW'(1);
          if (count == LAST) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          clear      = 1'b1;
          count_next = '0;
          state_next = IDLE;
        end
      end
      default: begin
        clear      = 1'b1;
        count_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  // State and digit counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Q/QM registers: load a step on accept, return to 0/-1 after handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q  <= '0;
      qm <= '1;
    end else if (clear) begin
      q  <= '0;
      qm <= '1;
    end else if (load) begin
      q  <= q_step;
      qm <= qm_step;
    end
  end

  // Handshake outputs follow the state directly.
  always_comb begin
    in_ready  = (state != DONE);
    out_valid = (state == DONE);
    out_value = q;
    dbg_state = state;
  end

`ifdef RR_OTF_DIGIT_CHECK_EN
  logic digit_illegal;

  // The only illegal code is -RADIX: sign bit set, magnitude bits zero.
  always_comb begin
    digit_illegal = in_digit[D-1] && (in_digit[K-1:0] == '0);
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_err <= 1'b0;
    end else if (load && digit_illegal) begin
      digit_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rr_otf_convert.sv
// Bench for rr_otf_convert: three instances (RADIX/N = 4/3, 2/4, 8/2)
// driven with directed digit sequences; expected results are queued when
// a sequence starts and popped by per-instance monitors on result handoff.
module tb_rr_otf_convert;
  import rr_msdf_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: RADIX 4, N 3 ----------------
  logic       in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [2:0] in_digit_a;
  logic [6:0] out_value_a;
  logic [1:0] dbg_a;
`ifdef RR_OTF_DIGIT_CHECK_EN
  logic       digit_err_a;
`endif

  rr_otf_convert #(.RADIX(4), .N(3)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_a),
    .in_digit  (in_digit_a),
    .in_ready  (in_ready_a),
    .out_valid (out_valid_a),
    .out_value (out_value_a),
    .out_ready (out_ready_a),
    .dbg_state (dbg_a)
`ifdef RR_OTF_DIGIT_CHECK_EN
    ,
    .digit_err (digit_err_a)
`endif
  );

  // ---------------- DUT B: RADIX 2, N 4 ----------------
  logic       in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [1:0] in_digit_b;
  logic [4:0] out_value_b;
  logic [1:0] dbg_b;
`ifdef RR_OTF_DIGIT_CHECK_EN
  logic       digit_err_b;
`endif

  rr_otf_convert #(.RADIX(2), .N(4)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_b),
    .in_digit  (in_digit_b),
    .in_ready  (in_ready_b),
    .out_valid (out_valid_b),
    .out_value (out_value_b),
    .out_ready (out_ready_b),
    .dbg_state (dbg_b)
`ifdef RR_OTF_DIGIT_CHECK_EN
    ,
    .digit_err (digit_err_b)
`endif
  );

  // ---------------- DUT C: RADIX 8, N 2 ----------------
  logic       in_valid_c, in_ready_c, out_valid_c, out_ready_c;
  logic [3:0] in_digit_c;
  logic [6:0] out_value_c;
  logic [1:0] dbg_c;
`ifdef RR_OTF_DIGIT_CHECK_EN
  logic       digit_err_c;
`endif

  rr_otf_convert #(.RADIX(8), .N(2)) u_dut_c (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_c),
    .in_digit  (in_digit_c),
    .in_ready  (in_ready_c),
    .out_valid (out_valid_c),
    .out_value (out_value_c),
    .out_ready (out_ready_c),
    .dbg_state (dbg_c)
`ifdef RR_OTF_DIGIT_CHECK_EN
    ,
    .digit_err (digit_err_c)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [6:0] exp_a[$];
  logic [4:0] exp_b[$];
  logic [6:0] exp_c[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected result 0x%0h with empty expected queue", name, act);
  endtask

  // Monitors: compare each result as it is handed off.
  always @(negedge clk) begin
    if (rst_n && out_valid_a && out_ready_a) begin
      if (exp_a.size() == 0) unexpected("mon_a", 32'(out_value_a));
      else check("mon_a", 32'(out_value_a), 32'(exp_a.pop_front()));
    end
    if (rst_n && out_valid_b && out_ready_b) begin
      if (exp_b.size() == 0) unexpected("mon_b", 32'(out_value_b));
      else check("mon_b", 32'(out_value_b), 32'(exp_b.pop_front()));
    end
    if (rst_n && out_valid_c && out_ready_c) begin
      if (exp_c.size() == 0) unexpected("mon_c", 32'(out_value_c));
      else check("mon_c", 32'(out_value_c), 32'(exp_c.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  // Each send starts 1 time unit after a rising edge and returns 1 time
  // unit after the edge that accepted the digit.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_a(input logic [2:0] d);
    int t;
    t = 0;
    in_valid_a = 1'b1;
    in_digit_a = d;
    while (!in_ready_a && t < 50) begin step(); t++; end
    if (!in_ready_a) begin
      n_vec++; n_err++;
      $display("FAIL send_a: in_ready stuck at %0b, want 1", in_ready_a);
    end else begin
      step();
    end
    in_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] d);
    int t;
    t = 0;
    in_valid_b = 1'b1;
    in_digit_b = d;
    while (!in_ready_b && t < 50) begin step(); t++; end
    if (!in_ready_b) begin
      n_vec++; n_err++;
      $display("FAIL send_b: in_ready stuck at %0b, want 1", in_ready_b);
    end else begin
      step();
    end
    in_valid_b = 1'b0;
  endtask

  task automatic send_c(input logic [3:0] d);
    int t;
    t = 0;
    in_valid_c = 1'b1;
    in_digit_c = d;
    while (!in_ready_c && t < 50) begin step(); t++; end
    if (!in_ready_c) begin
      n_vec++; n_err++;
      $display("FAIL send_c: in_ready stuck at %0b, want 1", in_ready_c);
    end else begin
      step();
    end
    in_valid_c = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    in_valid_a = 1'b0; in_digit_a = '0; out_ready_a = 1'b1;
    in_valid_b = 1'b0; in_digit_b = '0; out_ready_b = 1'b1;
    in_valid_c = 1'b0; in_digit_c = '0; out_ready_c = 1'b1;

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {29'd0, in_ready_a, in_ready_b, in_ready_c}, 32'h7);
    check("rst_out_valid", {29'd0, out_valid_a, out_valid_b, out_valid_c}, 32'h0);
    check("rst_value_a", 32'(out_value_a), 32'h0);
    check("rst_state_a", 32'(dbg_a), 32'(IDLE));
`ifdef RR_OTF_DIGIT_CHECK_EN
    check("rst_err_a", 32'(digit_err_a), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // A: 1,-2,3 -> 11, latency one cycle after the third accept.
    exp_a.push_back(7'd11);
    send_a(3'b001);
    send_a(3'b110);
    check("a_valid_early", 32'(out_valid_a), 32'h0);
    send_a(3'b011);
    check("a_latency", 32'(out_valid_a), 32'h1);
    check("a_in_ready_done", 32'(in_ready_a), 32'h0);

    // A: -1,0,0 -> -16 ; 3,3,3 -> 63 ; -3,-3,-3 -> -63.
    exp_a.push_back(7'b1110000);
    send_a(3'b111); send_a(3'b000); send_a(3'b000);
    exp_a.push_back(7'b0111111);
    send_a(3'b011); send_a(3'b011); send_a(3'b011);
    exp_a.push_back(7'b1000001);
    send_a(3'b101); send_a(3'b101); send_a(3'b101);

    // A: -1,-4,-1 -> -33 (illegal -4 taken arithmetically, last digit uses QM).
    exp_a.push_back(7'b1011111);
    send_a(3'b111);
`ifdef RR_OTF_DIGIT_CHECK_EN
    check("a_err_before", 32'(digit_err_a), 32'h0);
`endif
    send_a(3'b100);
`ifdef RR_OTF_DIGIT_CHECK_EN
    check("a_err_set", 32'(digit_err_a), 32'h1);
`endif
    send_a(3'b111);

    // A: one more conversion; the error flag must survive it.
    exp_a.push_back(7'd11);
    send_a(3'b001); send_a(3'b110); send_a(3'b011);
    step();
`ifdef RR_OTF_DIGIT_CHECK_EN
    check("a_err_sticky", 32'(digit_err_a), 32'h1);
`endif

    // B: 1,-1,1,-1 with gaps -> 5, held 5 cycles with out_ready low.
    out_ready_b = 1'b0;
    exp_b.push_back(5'd5);
    send_b(2'b01);
    idle(2);
    check("b_stall_state", 32'(dbg_b), 32'(ACCUM));
    send_b(2'b11);
    idle(1);
    send_b(2'b01);
    idle(3);
    check("b_stall_valid", 32'(out_valid_b), 32'h0);
    send_b(2'b11);
    check("b_latency", 32'(out_valid_b), 32'h1);
    for (int i = 0; i < 5; i++) begin
      in_valid_b = 1'b1;
      in_digit_b = 2'b01;
      check("b_hold_value", 32'(out_value_b), 32'd5);
      check("b_hold_ready", 32'(in_ready_b), 32'h0);
      check("b_hold_valid", 32'(out_valid_b), 32'h1);
      step();
    end
    in_valid_b  = 1'b0;
    out_ready_b = 1'b1;
    step();
    check("b_release_state", 32'(dbg_b), 32'(IDLE));
    check("b_release_value", 32'(out_value_b), 32'h0);

    // B: -1,-1,-1,-1 -> -15; digits offered in DONE must not leak in.
    exp_b.push_back(5'b10001);
    send_b(2'b11); send_b(2'b11); send_b(2'b11); send_b(2'b11);
    step();

    // C: 7,-7 -> 49.
    exp_c.push_back(7'd49);
    send_c(4'b0111);
    send_c(4'b1001);
    step();

    // C: reset after the first digit of a new result discards it.
    send_c(4'b0101);
    check("c_partial_state", 32'(dbg_c), 32'(ACCUM));
    check("c_partial_value", 32'(out_value_c), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("c_rst_state", 32'(dbg_c), 32'(IDLE));
    check("c_rst_value", 32'(out_value_c), 32'h0);
    check("c_rst_ready", 32'(in_ready_c), 32'h1);
    check("c_rst_valid", 32'(out_valid_c), 32'h0);
`ifdef RR_OTF_DIGIT_CHECK_EN
    check("c_rst_err_a", 32'(digit_err_a), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // C: 2,1 -> 17 after the reset.
    exp_c.push_back(7'd17);
    send_c(4'b0010);
    send_c(4'b0001);

    // Drain all expected results, bounded.
    for (int i = 0; i < 100 && (exp_a.size() + exp_b.size() + exp_c.size()) > 0; i++) step();
    check("drain_left", 32'(exp_a.size() + exp_b.size() + exp_c.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rr_otf_convert.md
RR_OTF_CONVERT -- requirements
Module: rr_otf_convert

Interface
REQ-001 SHALL have parameter RADIX, default 4, the digit radix; legal values are 2, 4 and 8.
REQ-002 SHALL have parameter N, default 8, the number of MSDF digits per result.
REQ-003 SHALL derive localparams K = log2(RADIX), D = K+1 (digit width) and W = N*K+1 (result width).
REQ-004 clk  input  1  rising-edge clock; the only clock.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 in_valid  input  1  in_digit holds a valid digit.
REQ-007 in_digit  input  D  signed-digit, two's complement, legal range -(RADIX-1)..RADIX-1, most significant digit first.
REQ-008 in_ready  output  1  converter accepts a digit this cycle.
REQ-009 out_valid  output  1  out_value holds a completed conversion.
REQ-010 out_value  output  W  two's-complement integer equal to the sum over i=1..N of d_i*RADIX^(N-i).
REQ-011 out_ready  input  1  consumer accepts out_value.
REQ-012 digit_err  output  1  sticky illegal-digit flag; present only when the macro of REQ-027 is defined.

Function
REQ-013 SHALL use on-the-fly conversion with registers Q and QM (QM = Q-1), each W bits; a digit is accepted on a clock edge where in_valid and in_ready are both high.
REQ-014 On each accepted digit d, Q SHALL become Q*RADIX+d if d>=0, else QM*RADIX+(RADIX+d).
REQ-015 On each accepted digit d, QM SHALL become Q*RADIX+(d-1) if d>0, else QM*RADIX+(RADIX-1+d).
REQ-016 No carry-propagate add of full width SHALL be used in the Q/QM update; the update is shift and digit append only.
REQ-017 SHALL implement a state machine with states IDLE, ACCUM and DONE.
REQ-018 IDLE: in_ready=1; the first accepted digit SHALL load Q/QM from the initial values Q=0, QM=-1, set count=1 and go to ACCUM; if N=1, go to DONE instead.
REQ-019 ACCUM: in_ready=1; each accepted digit SHALL increment count; the Nth digit SHALL go to DONE.
REQ-020 DONE: in_ready=0 and out_valid=1; out_value=Q SHALL be held stable until out_ready=1, then go to IDLE with Q=0 and QM=-1.
REQ-021 Cycles with in_valid=0 in ACCUM SHALL stall the conversion without changing state.
REQ-022 Latency: out_valid SHALL assert in the cycle after the edge accepting digit N; the earliest next digit is accepted the cycle after the out_ready handshake.
REQ-023 in_valid while in DONE SHALL be ignored and no digit consumed; out_ready outside DONE SHALL have no effect.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, Q=0, QM=all ones, count=0, out_valid=0 and digit_err=0; in_ready=1 after reset.
REQ-025 Reset mid-conversion SHALL discard all partial digits; the next accepted digit is treated as digit 1.

Configuration
REQ-026 Digit code -RADIX (MSB set, other bits zero) is illegal; without the checker it SHALL be converted arithmetically as -RADIX with no flag.
REQ-027 With RR_OTF_DIGIT_CHECK_EN defined: accepting an illegal digit SHALL set digit_err, which stays set until reset; conversion proceeds per REQ-026. Without the macro, the digit_err port and its logic are absent.

Structure
REQ-028 A shared package rr_msdf_pkg SHALL hold the digit-width function, the legal-radix check and the state enumeration (IDLE/ACCUM/DONE).
REQ-029 One sub-module, rr_otf_step, SHALL hold the combinational Q/QM next-value logic for one digit; the top holds the FSM, counter and registers.

Verification
REQ-030 RADIX=4, N=3, digits 1,-2,3 -> out_value=11 (7'b0001011); out_valid asserts the cycle after the third digit is accepted.
REQ-031 RADIX=4, N=3: digits -1,0,0 -> out_value=-16; digits 3,3,3 -> 63; digits -3,-3,-3 -> -63.
REQ-032 RADIX=2, N=4, digits 1,-1,1,-1 with in_valid gaps between digits -> out_value=5; out_ready held low 5 cycles -> value stable and in_ready=0 throughout.
REQ-033 RADIX=8, N=2, digits 7,-7 -> 49; then pulse rst_n low after the first digit of a new result -> outputs reach reset values, and digits 2,1 then give out_value=17.
REQ-034 With RR_OTF_DIGIT_CHECK_EN, RADIX=4 digit 3'b100 -> digit_err=1 the following cycle and it stays set after further conversions until reset.
